// File: rtl/ps2_display_pkg.sv
// Shared scan codes, prefix-state encoding and seven-segment glyphs ({g,f,e,d,c,b,a}, 0 = lit).
package ps2_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_EXT   = 2'd2
    } prefix_state_e;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    localparam logic [7:0] SC_0 = 8'h45, SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25;
    localparam logic [7:0] SC_5 = 8'h2E, SC_6 = 8'h36, SC_7 = 8'h3D, SC_8 = 8'h3E, SC_9 = 8'h46;
    localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23, SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33, SC_I = 8'h43;

    localparam logic [6:0] GLYPH_0 = 7'b1000000, GLYPH_1 = 7'b1111001, GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000, GLYPH_4 = 7'b0011001, GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010, GLYPH_7 = 7'b1111000, GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000, GLYPH_B = 7'b0000011, GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001, GLYPH_E = 7'b0000110, GLYPH_F = 7'b0001110;
    localparam logic [6:0] GLYPH_G = 7'b1000010, GLYPH_H = 7'b0001001, GLYPH_I = 7'b1111001;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

endpackage

// File: rtl/ps2_glyph_rom.sv
// Combinational scan-code to glyph lookup; hit_o flags a code that has a glyph.
module ps2_glyph_rom
    import ps2_display_pkg::*;
(
    input  logic [7:0] key_code_i,
    output logic       hit_o,
    output logic [6:0] glyph_o
);

    always_comb begin
        hit_o   = 1'b1;
        glyph_o = GLYPH_BLANK;
        case (key_code_i)
            SC_0: glyph_o = GLYPH_0;
            SC_1: glyph_o = GLYPH_1;
            SC_2: glyph_o = GLYPH_2;
            SC_3: glyph_o = GLYPH_3;
            SC_4: glyph_o = GLYPH_4;
            SC_5: glyph_o = GLYPH_5;
            SC_6: glyph_o = GLYPH_6;
            SC_7: glyph_o = GLYPH_7;
            SC_8: glyph_o = GLYPH_8;
            SC_9: glyph_o = GLYPH_9;
            SC_A: glyph_o = GLYPH_A;
            SC_B: glyph_o = GLYPH_B;
            SC_C: glyph_o = GLYPH_C;
            SC_D: glyph_o = GLYPH_D;
            SC_E: glyph_o = GLYPH_E;
            SC_F: glyph_o = GLYPH_F;
            SC_G: glyph_o = GLYPH_G;
            SC_H: glyph_o = GLYPH_H;
            SC_I: glyph_o = GLYPH_I;
            default: hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_scroll_display.sv
// PS/2 make-code tracker feeding a scrolling N-digit buffer, multiplexed onto a shared
// seven-segment bus. The buffer holds active-low glyphs; polarity is applied at the outputs.
module ps2_scroll_display
    import ps2_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  code_valid,
    input  logic [7:0]            key_code,
    input  logic                  clear,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  key_stb
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [6:0]            SEG_RESET = ACTIVE_LOW ? GLYPH_BLANK : ~GLYPH_BLANK;
    localparam logic [NUM_DIGITS-1:0] AN_RESET  = ACTIVE_LOW ? ~ONE_HOT0 : ONE_HOT0;

    prefix_state_e         state_q, state_d;
    logic [6:0]            disp_q [NUM_DIGITS];
    logic [6:0]            disp_d [NUM_DIGITS];
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  key_stb_q, key_stb_d;

    logic       rom_hit;
    logic [6:0] rom_glyph;
    logic       make_en, bksp_en;

    ps2_glyph_rom u_glyph_rom (
        .key_code_i (key_code),
        .hit_o      (rom_hit),
        .glyph_o    (rom_glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (key_code == SC_BREAK)    state_d = ST_BREAK;
                    else if (key_code == SC_EXT) state_d = ST_EXT;
                end
                ST_EXT:  state_d = (key_code == SC_BREAK) ? ST_BREAK : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Only bytes arriving in IDLE that are not prefixes act on the buffer.
    always_comb begin
        make_en = 1'b0;
        bksp_en = 1'b0;
        if (code_valid && !clear && state_q == ST_IDLE &&
            key_code != SC_BREAK && key_code != SC_EXT) begin
            if (key_code == SC_BKSP) bksp_en = 1'b1;
            else if (rom_hit)        make_en = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) disp_d[k] = disp_q[k];
        if (clear) begin
            for (int k = 0; k < NUM_DIGITS; k++) disp_d[k] = GLYPH_BLANK;
        end else if (make_en) begin
            for (int k = 1; k < NUM_DIGITS; k++) disp_d[k] = disp_q[k-1];
            disp_d[0] = rom_glyph;
        end else if (bksp_en) begin
            for (int k = 0; k < NUM_DIGITS - 1; k++) disp_d[k] = disp_q[k+1];
            disp_d[NUM_DIGITS-1] = GLYPH_BLANK;
        end
    end

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        idx_d     = idx_q;
        if (div_cnt_q == DIV_W'(REFRESH_DIV - 1)) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Output stage samples idx_q and the buffer together so an and seg always agree.
    always_comb begin
        seg_d     = ACTIVE_LOW ? disp_q[idx_q] : ~disp_q[idx_q];
        an_d      = ACTIVE_LOW ? ~(ONE_HOT0 << idx_q) : (ONE_HOT0 << idx_q);
        key_stb_d = make_en | bksp_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_DIGITS; k++) disp_q[k] <= GLYPH_BLANK;
            div_cnt_q <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_RESET;
            an_q      <= AN_RESET;
            key_stb_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) disp_q[k] <= disp_d[k];
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            key_stb_q <= key_stb_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign key_stb = key_stb_q;

endmodule
